// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and FIFO write-port bundle between NREQ producers, the
// write arbiter and the shared FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_wren;
  logic [WIDTH-1:0]      fifo_din;
  logic                  fifo_full;
  logic                  gnt_valid;
  logic [IDW-1:0]        gnt_id;

  // Environment side: producers and the FIFO.
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wren, fifo_din, gnt_valid, gnt_id
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wren, fifo_din, gnt_valid, gnt_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// A grant lasts up to MAXBURST accepted beats. It ends early when the
// granted requester drops valid. Each new arbitration costs one idle cycle.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 64,
  parameter int MAXBURST = 4
) (
  input logic             iclk,
  input logic             irstn,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] gnt_id, gnt_id_nx;
  logic [IDW-1:0] last_grant, last_grant_nx;
  logic           gnt_valid, gnt_valid_nx;
  logic [7:0]     beat_cnt, beat_cnt_nx;

  logic [IDW-1:0]   rr_pick;
  logic             rr_found;
  int               rr_idx;
  logic             slot_valid;
  logic [WIDTH-1:0] slot_data;
  logic [NREQ-1:0]  ready;
  logic             wren;
  logic [WIDTH-1:0] din;

  // Round-robin search: the first valid requester after last_grant, with wrap-around.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      rr_idx = (int'(last_grant) + i) % NREQ;
      if (!rr_found && bus.req_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = IDW'(rr_idx);
      end
    end
  end

  // Select the handshake lane of the currently granted requester.
  always_comb begin
    slot_valid = bus.req_valid[gnt_id];
    slot_data  = bus.req_data[int'(gnt_id)*WIDTH +: WIDTH];
  end

  // Next-state and output logic.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
    state_nx      = state;
    gnt_id_nx     = gnt_id;
    gnt_valid_nx  = gnt_valid;
    beat_cnt_nx   = beat_cnt;
    last_grant_nx = last_grant;
    ready         = '0;
    wren          = 1'b0;
    din           = '0;

    case (state)
      IDLE: begin
        if (rr_found) begin
          gnt_id_nx    = rr_pick;
          gnt_valid_nx = 1'b1;
          beat_cnt_nx  = '0;
          state_nx     = GRANT;
        end
      end
      GRANT: begin
        ready[gnt_id] = !bus.fifo_full;
        wren          = slot_valid && !bus.fifo_full;
        din           = slot_data;
        // A dropped valid releases the grant even when the FIFO is also full.
        if (!slot_valid || (wren && beat_cnt == 8'(MAXBURST - 1))) begin
          state_nx      = IDLE;
          gnt_valid_nx  = 1'b0;
          last_grant_nx = gnt_id;
          beat_cnt_nx   = '0;
        end else if (wren) begin
          beat_cnt_nx = beat_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // NOTE: reset is synchronous, so the registers still hold GRANT during the reset cycle; the handshake outputs are masked here so no beat leaks out then.
    if (!irstn) begin
      ready = '0;
      wren  = 1'b0;
      din   = '0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge iclk) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers update from the same pre-edge values.
    if (!irstn) begin
      state      <= IDLE;
      gnt_id     <= '0;
      gnt_valid  <= 1'b0;
      beat_cnt   <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      state      <= state_nx;
      gnt_id     <= gnt_id_nx;
      gnt_valid  <= gnt_valid_nx;
      beat_cnt   <= beat_cnt_nx;
      last_grant <= last_grant_nx;
    end
  end

  assign bus.req_ready = ready;
  assign bus.fifo_wren = wren;
  assign bus.fifo_din  = din;
  assign bus.gnt_valid = gnt_valid;
  assign bus.gnt_id    = gnt_id;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter. Each producer counts its accepted
// beats. Each FIFO write is compared against the queue of expected beats.
module tb_fifo_wr_arbiter;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 64;
  localparam int MAXBURST = 4;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] data;
  } beat_t;

  logic iclk;
  logic irstn;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXBURST(MAXBURST)) dut (
    .iclk (iclk),
    .irstn(irstn),
    .bus  (bus.slave)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  beat_t      sb[$];
  int         nvec = 0;
  int         nmis = 0;
  int         cyc  = 0;
  int         seq[NREQ];
  int         exp_seq[NREQ];

  logic             s_wren;
  logic [WIDTH-1:0] s_din;
  logic [NREQ-1:0]  s_ready;
  logic             s_gv;
  logic [1:0]       s_gid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mk(input int id, input int s);
    return {32'hA5A50000 + 32'(id), 32'(s)};
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = mk(i, seq[i]);
  endtask

  task automatic push_burst(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      sb.push_back('{id: 2'(id), data: mk(id, exp_seq[id])});
      exp_seq[id]++;
    end
  endtask

  // One clock: sample at the falling edge, score writes, then advance producers.
  task automatic tick();
    logic [NREQ-1:0] acc;
    beat_t e;
    @(negedge iclk);
    s_wren  = bus.fifo_wren;
    s_din   = bus.fifo_din;
    s_ready = bus.req_ready;
    s_gv    = bus.gnt_valid;
    s_gid   = bus.gnt_id;
    acc     = s_ready & bus.req_valid;
    if (s_wren === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_write", 64'(s_din), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        check("din", 64'(s_din), e.data);
        check("wr_id", 64'(s_gid), 64'(e.id));
      end
    end
    cyc++;
    if (cyc > 20000) begin
      $display("FAIL timeout: cycle budget exceeded");
      $fatal(1);
    end
    @(posedge iclk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) seq[i]++;
    drive_data();
  endtask

  task automatic do_reset();
    irstn = 1'b0;
    tick();
    check("rst_ready0", 64'(s_ready), 64'h0);
    check("rst_wren0", 64'(s_wren), 64'h0);
    tick();
    check("rst_ready1", 64'(s_ready), 64'h0);
    check("rst_wren1", 64'(s_wren), 64'h0);
    check("rst_gv", 64'(s_gv), 64'h0);
    check("rst_gid", 64'(s_gid), 64'h0);
    check("rst_din", 64'(s_din), 64'h0);
    irstn = 1'b1;
  endtask

  // Full-rate pattern: one idle cycle, then MAXBURST beats to the expected id.
  task automatic run_pattern(input string tag, input int ncyc, input int only_id);
    int exp_id;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      exp_id = (only_id >= 0) ? only_id : (k / 5) % NREQ;
      if (k % 5 == 0) begin
        check({tag, "_bubble_wren"}, 64'(s_wren), 64'h0);
        check({tag, "_bubble_gv"}, 64'(s_gv), 64'h0);
      end else begin
        check({tag, "_wren"}, 64'(s_wren), 64'h1);
        check({tag, "_gid"}, 64'(s_gid), 64'(exp_id));
        check({tag, "_ready"}, 64'(s_ready), 64'(1 << exp_id));
      end
    end
  endtask

  initial begin
    irstn         = 1'b0;
    bus.req_valid = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      seq[i]     = 0;
      exp_seq[i] = 0;
    end
    drive_data();

    // Reset with every requester valid, then round-robin at full rate.
    bus.req_valid = 4'b1111;
    do_reset();
    for (int g = 0; g < 5; g++) push_burst(g % NREQ, MAXBURST);
    run_pattern("rr", 25, -1);
    bus.req_valid = '0;
    check("rr_sb_left", 64'(sb.size()), 64'h0);

    // FIFO full stalls requester 1 mid-burst without releasing the grant.
    do_reset();
    bus.req_valid = 4'b0010;
    push_burst(1, MAXBURST);
    tick();
    check("full_idle_gv", 64'(s_gv), 64'h0);
    tick();
    tick();
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("full_ready", 64'(s_ready), 64'h0);
      check("full_wren", 64'(s_wren), 64'h0);
      check("full_gv", 64'(s_gv), 64'h1);
      check("full_gid", 64'(s_gid), 64'h1);
    end
    bus.fifo_full = 1'b0;
    tick();
    check("full_resume0", 64'(s_wren), 64'h1);
    tick();
    check("full_resume1", 64'(s_wren), 64'h1);
    bus.req_valid = '0;
    tick();
    check("full_release_gv", 64'(s_gv), 64'h0);
    check("full_sb_left", 64'(sb.size()), 64'h0);

    // Requester 2 drops valid after 2 beats while the FIFO also fills up.
    do_reset();
    bus.req_valid = 4'b0100;
    push_burst(2, 2);
    push_burst(3, 1);
    tick();
    bus.req_valid = 4'b1111;
    tick();
    tick();
    bus.req_valid = 4'b1011;
    bus.fifo_full = 1'b1;
    tick();
    check("drop_wren", 64'(s_wren), 64'h0);
    check("drop_gid", 64'(s_gid), 64'h2);
    bus.fifo_full = 1'b0;
    tick();
    check("drop_bubble_gv", 64'(s_gv), 64'h0);
    tick();
    check("drop_next_gv", 64'(s_gv), 64'h1);
    check("drop_next_gid", 64'(s_gid), 64'h3);
    check("drop_next_wren", 64'(s_wren), 64'h1);
    bus.req_valid = '0;
    tick();
    tick();
    check("drop_idle_gv", 64'(s_gv), 64'h0);
    check("drop_sb_left", 64'(sb.size()), 64'h0);

    // Lone requester 1 is granted repeatedly.
    do_reset();
    bus.req_valid = 4'b0010;
    push_burst(1, 4 * MAXBURST);
    run_pattern("solo", 20, 1);
    bus.req_valid = '0;
    check("solo_sb_left", 64'(sb.size()), 64'h0);

    // Reset in the middle of a burst from requester 3.
    do_reset();
    bus.req_valid = 4'b1000;
    push_burst(3, 2);
    tick();
    tick();
    tick();
    irstn = 1'b0;
    tick();
    check("midrst_wren", 64'(s_wren), 64'h0);
    check("midrst_ready", 64'(s_ready), 64'h0);
    tick();
    check("midrst_gv", 64'(s_gv), 64'h0);
    check("midrst_ready2", 64'(s_ready), 64'h0);
    check("midrst_sb_left", 64'(sb.size()), 64'h0);
    bus.req_valid = 4'b1111;
    irstn = 1'b1;
    push_burst(0, MAXBURST);
    tick();
    check("midrst_bubble_gv", 64'(s_gv), 64'h0);
    tick();
    check("midrst_first_gv", 64'(s_gv), 64'h1);
    check("midrst_first_gid", 64'(s_gid), 64'h0);
    tick();
    tick();
    tick();
    bus.req_valid = '0;
    tick();
    check("midrst_end_gv", 64'(s_gv), 64'h0);
    check("midrst_end_sb", 64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
